// File: rtl/video_stream_sink.sv
// video_stream_sink: AXI4-Stream RGB888 receiver. Unpacks 3 little-endian
// 32-bit words into 4 pixels, tags each pixel with x/y, checks line/frame
// framing, keeps sticky error flags and re-hunts for start of frame on error.
// Optional build macro VIDEO_SINK_CHECKSUM_EN adds a per-frame pixel checksum.
module video_stream_sink #(
  parameter int X_SIZE = 640,
  parameter int Y_SIZE = 480
) (
  input  logic        in_stream_aclk,
  input  logic        periph_resetn,
  input  logic [31:0] in_stream_tdata,
  input  logic [3:0]  in_stream_tkeep,
  input  logic        in_stream_tlast,
  input  logic        in_stream_tuser,
  input  logic        in_stream_tvalid,
  output logic        in_stream_tready,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        locked,
  output logic [15:0] frame_count,
  output logic [3:0]  err_flags,
  input  logic        err_clear
`ifdef VIDEO_SINK_CHECKSUM_EN
  ,
  output logic [31:0] frame_checksum
`endif
);

  localparam int WPL = X_SIZE * 3 / 4;
  localparam int WW  = (WPL > 1) ? $clog2(WPL) : 1;
  localparam logic [WW-1:0] WLAST = WW'(WPL - 1);
  localparam logic [9:0]    XLAST = 10'(X_SIZE - 1);
  localparam logic [8:0]    YLAST = 9'(Y_SIZE - 1);

  localparam logic [0:0] ST_HUNT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state;
  logic          rdy_en;   // holds tready low until the first clock after reset
  logic [1:0]    phase;
  logic [15:0]   res;      // leftover bytes of the current 3-word group
  logic [WW-1:0] wcnt;
  logic [8:0]    lcnt;
  logic [9:0]    cnt_x;    // coordinates of the next pixel to be loaded
  logic [8:0]    cnt_y;
  logic          pend;     // pixel 3 of a group waiting for the output register
  logic [23:0]   p3;

  logic          accept, in_run, bad, lock_word, run_word, take, err_word;
  logic          hs, pend_go, load, frame_end;
  logic [3:0]    err_set;
  logic [1:0]    ph_e;
  logic [WW-1:0] wc_e;
  logic [8:0]    lc_e;
  logic [9:0]    ld_x, nx;
  logic [8:0]    ld_y, ny;
  logic [23:0]   px_word, ld_px;

  assign in_stream_tready = rdy_en & (!pix_valid | pix_ready) & !pend;
  assign accept    = in_stream_tvalid & in_stream_tready;
  assign in_run    = (state == ST_RUN);
  assign locked    = in_run;

  assign err_set[0] = in_stream_tkeep != 4'hF;
  assign err_set[1] = in_stream_tlast & (wcnt != WLAST);
  assign err_set[2] = (wcnt == WLAST) & !in_stream_tlast;
  assign err_set[3] = in_stream_tuser != ((wcnt == '0) && (lcnt == 9'd0));
  assign bad        = |err_set;
  assign err_word   = accept & in_run & bad;

  // a tuser word starts a new frame from HUNT or straight out of an error
  assign lock_word = accept & in_stream_tuser & (!in_run | bad);
  assign run_word  = accept & in_run & !bad;
  assign take      = lock_word | run_word;

  assign ph_e = lock_word ? 2'd0 : phase;
  assign wc_e = lock_word ? '0   : wcnt;
  assign lc_e = lock_word ? 9'd0 : lcnt;

  assign hs        = pix_valid & pix_ready;
  assign pend_go   = pend & hs;
  assign load      = take | pend_go;
  assign frame_end = hs & pix_eol & (pix_y == YLAST);

  // pixel carried by the accepted word, packed {r,g,b}
  always_comb begin
    px_word = {in_stream_tdata[7:0], in_stream_tdata[15:8], in_stream_tdata[23:16]};
    case (ph_e)
      2'd1:    px_word = {res[7:0], in_stream_tdata[7:0], in_stream_tdata[15:8]};
      2'd2:    px_word = {res[7:0], res[15:8], in_stream_tdata[7:0]};
      default: px_word = {in_stream_tdata[7:0], in_stream_tdata[15:8], in_stream_tdata[23:16]};
    endcase
  end

  // source and coordinates of whatever is loaded into the output register
  always_comb begin
    ld_px = take ? px_word : p3;
    ld_x  = take ? (lock_word ? 10'd0 : cnt_x) : cnt_x;
    ld_y  = take ? (lock_word ? 9'd0  : cnt_y) : cnt_y;
    nx    = (ld_x == XLAST) ? 10'd0 : ld_x + 10'd1;
    ny    = ld_y;
    if (ld_x == XLAST) ny = (ld_y == YLAST) ? 9'd0 : ld_y + 9'd1;
  end

  // HUNT/RUN tracking
  always_ff @(posedge in_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      state  <= ST_HUNT;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (lock_word)     state <= ST_RUN;
      else if (err_word) state <= ST_HUNT;
    end
  end

  // group phase, residue bytes and word/line position
  always_ff @(posedge in_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      phase <= 2'd0;
      res   <= 16'h0;
      wcnt  <= '0;
      lcnt  <= 9'd0;
    end else if (take) begin
      phase <= (ph_e == 2'd2) ? 2'd0 : ph_e + 2'd1;
      if (ph_e == 2'd0) res[7:0] <= in_stream_tdata[31:24];
      if (ph_e == 2'd1) res      <= in_stream_tdata[31:16];
      wcnt <= (wc_e == WLAST) ? '0 : wc_e + WW'(1);
      if (wc_e == WLAST) lcnt <= (lc_e == YLAST) ? 9'd0 : lc_e + 9'd1;
      else               lcnt <= lc_e;
    end
  end

  // second pixel of a phase-2 word waits here until the first is taken
  always_ff @(posedge in_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      pend <= 1'b0;
      p3   <= 24'h0;
    end else if (take && ph_e == 2'd2) begin
      pend <= 1'b1;
      p3   <= {in_stream_tdata[15:8], in_stream_tdata[23:16], in_stream_tdata[31:24]};
    end else if (pend_go) begin
      pend <= 1'b0;
    end
  end

  // pixel output register; held while valid and not ready
  always_ff @(posedge in_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      {pix_r, pix_g, pix_b} <= 24'h0;
      pix_x     <= 10'd0;
      pix_y     <= 9'd0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
      pix_valid <= 1'b0;
      cnt_x     <= 10'd0;
      cnt_y     <= 9'd0;
    end else if (load) begin
      {pix_r, pix_g, pix_b} <= ld_px;
      pix_x     <= ld_x;
      pix_y     <= ld_y;
      pix_sof   <= (ld_x == 10'd0) && (ld_y == 9'd0);
      pix_eol   <= (ld_x == XLAST);
      pix_valid <= 1'b1;
      cnt_x     <= nx;
      cnt_y     <= ny;
    end else if (pix_ready) begin
      pix_valid <= 1'b0;
    end
  end

  // frames counted when their last pixel leaves
  always_ff @(posedge in_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) frame_count <= 16'd0;
    else if (frame_end) frame_count <= frame_count + 16'd1;
  end

  // sticky errors; a flag being set this cycle survives err_clear
  always_ff @(posedge in_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) err_flags <= 4'h0;
    else err_flags <= (err_clear ? 4'h0 : err_flags) | ((accept & in_run) ? err_set : 4'h0);
  end

`ifdef VIDEO_SINK_CHECKSUM_EN
  logic [31:0] acc;
  logic [31:0] cur;
  assign cur = {8'h00, pix_r, pix_g, pix_b};

  // per-frame sum of delivered pixels, restarted on loss of lock
  always_ff @(posedge in_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      acc            <= 32'h0;
      frame_checksum <= 32'h0;
    end else begin
      if (frame_end) frame_checksum <= acc + cur;
      if (err_word || frame_end) acc <= 32'h0;
      else if (hs)               acc <= acc + cur;
    end
  end
`endif

endmodule

// File: tb/tb_video_stream_sink.sv
// Directed bench for video_stream_sink with X_SIZE=8, Y_SIZE=2 (6 words/line).
// Pixel expectations come from a byte-packing model and are checked in order
// by a scoreboard queue at every pixel handshake.
module tb_video_stream_sink;
  logic        in_stream_aclk = 1'b0;
  logic        periph_resetn  = 1'b1;
  logic [31:0] in_stream_tdata = '0;
  logic [3:0]  in_stream_tkeep = 4'hF;
  logic        in_stream_tlast = 1'b0, in_stream_tuser = 1'b0, in_stream_tvalid = 1'b0;
  logic        in_stream_tready;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        pix_sof, pix_eol, pix_valid, locked;
  logic        pix_ready = 1'b1;
  logic [15:0] frame_count;
  logic [3:0]  err_flags;
  logic        err_clear = 1'b0;
`ifdef VIDEO_SINK_CHECKSUM_EN
  logic [31:0] frame_checksum;
`endif

  video_stream_sink #(.X_SIZE(8), .Y_SIZE(2)) dut (
    .in_stream_aclk(in_stream_aclk), .periph_resetn(periph_resetn),
    .in_stream_tdata(in_stream_tdata), .in_stream_tkeep(in_stream_tkeep),
    .in_stream_tlast(in_stream_tlast), .in_stream_tuser(in_stream_tuser),
    .in_stream_tvalid(in_stream_tvalid), .in_stream_tready(in_stream_tready),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_x(pix_x), .pix_y(pix_y),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .locked(locked), .frame_count(frame_count), .err_flags(err_flags),
    .err_clear(err_clear)
`ifdef VIDEO_SINK_CHECKSUM_EN
    , .frame_checksum(frame_checksum)
`endif
  );

  always #5 in_stream_aclk = ~in_stream_aclk;

  int checks = 0;
  int errs   = 0;
  logic [7:0]  pr[16], pg[16], pb[16];
  logic [31:0] fw[12];
  logic [44:0] q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every handshaken pixel must match the head of the queue
  always @(negedge in_stream_aclk) begin
    if (pix_valid && pix_ready) begin
      checks++;
      assert (q.size() != 0) else begin
        errs++;
        $error("FAIL unexpected_pixel got x=%0d y=%0d exp none", pix_x, pix_y);
      end
      if (q.size() != 0) begin
        logic [44:0] e;
        logic [44:0] g;
        e = q.pop_front();
        g = {pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol};
        checks++;
        assert (g === e) else begin
          errs++;
          $error("FAIL pixel got=%0h exp=%0h", g, e);
        end
      end
    end
  end

  // frame of 16 pixels packed into 12 little-endian words
  task automatic build(input bit cst, input int base);
    logic [7:0] by[48];
    for (int k = 0; k < 16; k++) begin
      pr[k] = cst ? 8'h01 : 8'(base + 3*k);
      pg[k] = cst ? 8'h02 : 8'(base + 3*k + 1);
      pb[k] = cst ? 8'h03 : 8'(base + 3*k + 2);
      by[3*k] = pr[k]; by[3*k+1] = pg[k]; by[3*k+2] = pb[k];
    end
    for (int i = 0; i < 12; i++) fw[i] = {by[4*i+3], by[4*i+2], by[4*i+1], by[4*i]};
  endtask

  task automatic push_px(input int k);
    q.push_back({pr[k], pg[k], pb[k], 10'(k % 8), 9'(k / 8), k == 0, (k % 8) == 7});
  endtask

  // pixels that word i of a frame is expected to produce
  task automatic push_word(input int i);
    int ln, wl, px;
    ln = i / 6; wl = i % 6; px = ln*8 + 4*(wl/3);
    case (wl % 3)
      0: push_px(px);
      1: push_px(px + 1);
      default: begin push_px(px + 2); push_px(px + 3); end
    endcase
  endtask

  // drive one word, wait for acceptance, return #1 after the accepting edge
  task automatic send(input int i, input logic [3:0] keep, input logic last, input logic user, input bit expx);
    int n;
    in_stream_tdata = fw[i]; in_stream_tkeep = keep; in_stream_tlast = last;
    in_stream_tuser = user; in_stream_tvalid = 1'b1;
    n = 0;
    @(negedge in_stream_aclk);
    while (!in_stream_tready && n < 50) begin @(negedge in_stream_aclk); n++; end
    chk("tready_wait", in_stream_tready, 1);
    if (expx) push_word(i);
    @(posedge in_stream_aclk); #1;
    in_stream_tvalid = 1'b0; in_stream_tuser = 1'b0; in_stream_tlast = 1'b0;
  endtask

  task automatic send_frame(input int bp);
    for (int i = 0; i < 12; i++) begin
      send(i, 4'hF, (i % 6) == 5, i == 0, 1'b1);
      if (i == bp) begin
        logic [33:0] snap;
        @(posedge in_stream_aclk); #1;
        pix_ready = 1'b0;
        snap = {pix_r, pix_g, pix_b, pix_x};
        chk("bp_valid", pix_valid, 1);
        chk("bp_x", pix_x, 3);
        @(posedge in_stream_aclk); #1;
        chk("bp_tready", in_stream_tready, 0);
        chk("bp_hold1", {pix_r, pix_g, pix_b, pix_x}, snap);
        @(posedge in_stream_aclk); #1;
        chk("bp_hold2", {pix_valid, pix_r, pix_g, pix_b, pix_x}, {1'b1, snap});
        pix_ready = 1'b1;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin @(negedge in_stream_aclk); n++; end
    chk("drain", q.size(), 0);
    repeat (2) @(posedge in_stream_aclk);
    #1;
  endtask

  task automatic clear_pulse();
    err_clear = 1'b1;
    @(posedge in_stream_aclk); #1;
    err_clear = 1'b0;
    chk("err_clear", err_flags, 4'h0);
  endtask

  initial begin
    // reset state
    #1 periph_resetn = 1'b0;
    #2;
    chk("rst_tready", in_stream_tready, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_fc", frame_count, 0);
    chk("rst_err", err_flags, 0);
    @(negedge in_stream_aclk) periph_resetn = 1'b1;
    repeat (2) @(negedge in_stream_aclk);

    // words before any tuser are dropped
    build(1'b1, 0);
    chk("hunt_tready", in_stream_tready, 1);
    for (int i = 1; i < 4; i++) send(i, 4'hF, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge in_stream_aclk); #1;
    chk("hunt_valid", pix_valid, 0);
    chk("hunt_locked", locked, 0);

    // two clean constant frames; first tuser word gives (0,0) next cycle
    send(0, 4'hF, 1'b0, 1'b1, 1'b1);
    chk("first_px", {pix_valid, pix_sof, 10'(pix_x), 9'(pix_y)}, {1'b1, 1'b1, 10'd0, 9'd0});
    for (int i = 1; i < 12; i++) send(i, 4'hF, (i % 6) == 5, 1'b0, 1'b1);
    send_frame(-1);
    drain();
    chk("t1_fc", frame_count, 2);
    chk("t1_err", err_flags, 0);
    chk("t1_locked", locked, 1);
`ifdef VIDEO_SINK_CHECKSUM_EN
    chk("t1_checksum", frame_checksum, 32'h00102030);
`endif

    // backpressure across the phase-2 word
    build(1'b0, 8'h10);
    send_frame(2);
    drain();
    chk("t2_fc", frame_count, 3);

    // early tlast on word 3
    build(1'b0, 8'h40);
    for (int i = 0; i < 3; i++) send(i, 4'hF, 1'b0, i == 0, 1'b1);
    send(3, 4'hF, 1'b1, 1'b0, 1'b0);
    drain();
    chk("t3_err", err_flags, 4'b0010);
    chk("t3_locked", locked, 0);
    for (int i = 4; i < 9; i++) send(i, 4'hF, (i % 6) == 5, 1'b0, 1'b0);
    send_frame(-1);
    drain();
    chk("t3_fc", frame_count, 4);
    chk("t3_sticky", err_flags, 4'b0010);
    chk("t3_relocked", locked, 1);

    // tkeep error on word 2, coinciding with err_clear: the new flag wins
    build(1'b0, 8'h80);
    send(0, 4'hF, 1'b0, 1'b1, 1'b1);
    send(1, 4'hF, 1'b0, 1'b0, 1'b1);
    err_clear = 1'b1;
    send(2, 4'h7, 1'b0, 1'b0, 1'b0);
    err_clear = 1'b0;
    drain();
    chk("t4_err", err_flags, 4'b0001);
    chk("t4_locked", locked, 0);
    clear_pulse();

    // tuser mid-line: sof_err and immediate re-lock on that word
    build(1'b0, 8'hC3);
    send(0, 4'hF, 1'b0, 1'b1, 1'b1);
    send(1, 4'hF, 1'b0, 1'b0, 1'b1);
    send_frame(-1);
    drain();
    chk("relock_err", err_flags, 4'b1000);
    chk("relock_locked", locked, 1);
    chk("relock_fc", frame_count, 5);
    clear_pulse();

    // missing tlast on the last word of a line
    for (int i = 0; i < 5; i++) send(i, 4'hF, 1'b0, i == 0, 1'b1);
    send(5, 4'hF, 1'b0, 1'b0, 1'b0);
    drain();
    chk("late_eol", err_flags, 4'b0100);
    chk("late_locked", locked, 0);
    clear_pulse();

    // missing tuser at a frame start while locked
    send_frame(-1);
    send(0, 4'hF, 1'b0, 1'b0, 1'b0);
    drain();
    chk("nosof_fc", frame_count, 6);
    chk("nosof_err", err_flags, 4'b1000);
    chk("nosof_locked", locked, 0);

    // asynchronous reset with a pixel held at the output
    pix_ready = 1'b0;
    send(0, 4'hF, 1'b0, 1'b1, 1'b0);
    chk("pre_rst_valid", pix_valid, 1);
    #3 periph_resetn = 1'b0;
    #1;
    chk("arst_out", {pix_valid, in_stream_tready, locked}, 3'b000);
    q.delete();
    @(negedge in_stream_aclk) begin periph_resetn = 1'b1; pix_ready = 1'b1; end
    repeat (2) @(negedge in_stream_aclk);
    chk("arst_fc", frame_count, 0);
    chk("arst_hunt", {locked, in_stream_tready}, 2'b01);
    for (int i = 1; i < 4; i++) send(i, 4'hF, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge in_stream_aclk); #1;
    chk("arst_still_hunt", locked, 0);
    send_frame(-1);
    drain();
    chk("final_fc", frame_count, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
